// File: rtl/serial_sign_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_sign_unit
// Purpose  : Multi-cycle sign manipulation (NEG / ABS / SETSIGN / PASS) of a
//            WIDTH-bit operand. It processes CHUNK bits per cycle, LSB first,
//            and ripples the two's-complement increment carry between slices.
//            Every op takes exactly N = WIDTH/CHUNK RUN cycles.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready      operand handshake (op, sign_in, a)
//            out_valid/out_ready    result handshake (r, overflow)
//            busy                   unit not idle
// Revision : 1.0  initial release
// ============================================================================
module serial_sign_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             sign_in,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             overflow,
    output logic             busy
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_OP_NEG     = 2'b00;
    localparam logic [1:0] c_OP_ABS     = 2'b01;
    localparam logic [1:0] c_OP_SETSIGN = 2'b10;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;        // latched operand, shifted right one slice per RUN cycle
    logic [WIDTH-1:0] r_result;   // result, filled from the top and shifted down
    logic             r_neg_en;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;

    logic             w_accept;
    logic             w_neg_en;
    logic             w_ovf;
    logic [CHUNK-1:0] w_slice;
    logic [CHUNK:0]   w_sum;
    logic [CHUNK-1:0] w_slice_out;
    logic [WIDTH-1:0] w_result_next;

    assign w_accept = in_valid && (r_state == c_IDLE);

    assign w_neg_en = (op == c_OP_NEG)
                    | ((op == c_OP_ABS) & a[WIDTH-1])
                    | ((op == c_OP_SETSIGN) & sign_in);

    // Overflow depends only on the incoming operand, so it is resolved at
    // acceptance and simply held until the result is consumed.
    always_comb begin
        w_ovf = 1'b0;
        case (op)
            c_OP_NEG:     w_ovf = (a == c_MIN);
            c_OP_SETSIGN: w_ovf = sign_in ? (a > c_MIN) : a[WIDTH-1];
            default:      w_ovf = 1'b0;
        endcase
    end

    // One CHUNK-bit incrementer: ~slice + carry, carry-out feeds the next slice.
    assign w_slice     = r_a[CHUNK-1:0];
    assign w_sum       = {1'b0, ~w_slice} + {{CHUNK{1'b0}}, r_carry};
    assign w_slice_out = r_neg_en ? w_sum[CHUNK-1:0] : w_slice;

    // After N shifts slice 0 lands at the bottom of the result register.
    generate
        if (CHUNK == WIDTH) begin : g_single_slice
            assign w_result_next = w_slice_out;
        end else begin : g_multi_slice
            assign w_result_next = {w_slice_out, r_result[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_a        <= '0;
            r_result   <= '0;
            r_neg_en   <= 1'b0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_a        <= a;
                        r_neg_en   <= w_neg_en;
                        r_carry    <= w_neg_en;
                        r_cnt      <= '0;
                        r_overflow <= w_ovf;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_result <= w_result_next;
                    r_a      <= r_a >> CHUNK;
                    r_carry  <= r_neg_en & w_sum[CHUNK];
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign r         = r_result;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
